// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate reduction: sums cfg_vector_len valid samples, then
// emits one arithmetically-shifted, saturated DATA_WIDTH result with a valid pulse.
module mac_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  cfg_vector_len,
  input  logic [3:0]            cfg_shift,
  input  logic                  acc_clear,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic                  in_tvalid,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  output logic                  out_sat,
  output logic                  busy
);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                        state, state_next;
  logic signed [ACC_WIDTH-1:0]   acc, acc_next, sum, shifted, sample_ext;
  logic [LEN_WIDTH-1:0]          count, count_next, len_q, len_next, len_eff;
  logic [3:0]                    shift_q, shift_next, shift_sel;
  logic                          done;
  logic [DATA_WIDTH-1:0]         res;
  logic                          res_sat;
  logic [ACC_WIDTH-DATA_WIDTH:0] hi;

  always_comb begin
    sample_ext = {{(ACC_WIDTH-DATA_WIDTH){in_tdata[DATA_WIDTH-1]}}, in_tdata};
    len_eff    = (cfg_vector_len == '0) ? LEN_WIDTH'(1) : cfg_vector_len;
    state_next = state;
    acc_next   = acc;
    count_next = count;
    len_next   = len_q;
    shift_next = shift_q;
    shift_sel  = shift_q;
    sum        = acc + sample_ext;
    done       = 1'b0;

    if (acc_clear) begin
      state_next = IDLE;
      acc_next   = '0;
      count_next = '0;
    end else if (in_tvalid) begin
      case (state)
        IDLE: begin
          // The first sample uses the live config, which is also latched for the rest of the vector.
          len_next   = len_eff;
          shift_next = cfg_shift;
          shift_sel  = cfg_shift;
          sum        = sample_ext;
          acc_next   = sum;
          count_next = LEN_WIDTH'(1);
          if (len_eff == LEN_WIDTH'(1)) begin
            done       = 1'b1;
            acc_next   = '0;
            count_next = '0;
          end else begin
            state_next = ACCUM;
          end
        end
        ACCUM: begin
          acc_next   = sum;
          count_next = count + LEN_WIDTH'(1);
          if (count + LEN_WIDTH'(1) == len_q) begin
            done       = 1'b1;
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Fits in DATA_WIDTH exactly when all bits above the result sign bit match it.
    shifted = sum >>> shift_sel;
    hi      = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
    if (hi == '0 || hi == '1) begin
      res     = shifted[DATA_WIDTH-1:0];
      res_sat = 1'b0;
    end else begin
      res     = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                     : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      count      <= '0;
      len_q      <= '0;
      shift_q    <= '0;
      out_tdata  <= '0;
      out_tvalid <= 1'b0;
      out_sat    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      acc        <= acc_next;
      count      <= count_next;
      len_q      <= len_next;
      shift_q    <= shift_next;
      out_tvalid <= done;
      out_tdata  <= done ? res : '0;
      out_sat    <= done & res_sat;
      busy       <= (state_next == ACCUM);
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: table of vectors plus hand-written clear/reset
// sequences, with a cycle-stamped scoreboard checked by a negedge monitor.
module tb_mac_accumulator;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] cfg_vector_len;
  logic [3:0]    cfg_shift;
  logic          acc_clear;
  logic [DW-1:0] in_tdata;
  logic          in_tvalid;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_sat;
  logic          busy;

  mac_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .cfg_vector_len(cfg_vector_len), .cfg_shift(cfg_shift),
    .acc_clear(acc_clear), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    logic [LW-1:0]        len;
    logic [3:0]           shift;
    int                   gap;
    int                   n;
    logic signed [DW-1:0] s [4];
    logic signed [DW-1:0] exp_data;
    logic                 exp_sat;
  } vec_t;

  typedef struct {
    logic signed [DW-1:0] data;
    logic                 sat;
    int                   cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int len, input int sh, input int gap, input int n,
                              input int a, input int b, input int c, input int d,
                              input int ed, input int es);
    vec_t v;
    v.len      = LW'(len);
    v.shift    = 4'(sh);
    v.gap      = gap;
    v.n        = n;
    v.s[0]     = DW'(a);
    v.s[1]     = DW'(b);
    v.s[2]     = DW'(c);
    v.s[3]     = DW'(d);
    v.exp_data = DW'(ed);
    v.exp_sat  = es[0];
    return v;
  endfunction

  // Config is scrambled after the first sample so a design that fails to latch it misbehaves.
  task automatic send(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      cfg_vector_len = (i == 0) ? v.len : LW'(1);
      cfg_shift      = (i == 0) ? v.shift : 4'd15;
      in_tdata       = v.s[i];
      in_tvalid      = 1'b1;
      if (i == v.n - 1) sbq.push_back('{v.exp_data, v.exp_sat, cyc + 1});
      @(posedge clk); #1;
      in_tvalid = 1'b0;
      if (i < v.n - 1) begin
        chk("busy_mid", busy, 1);
        repeat (v.gap) begin
          @(posedge clk); #1;
          chk("busy_gap", busy, 1);
        end
      end else begin
        chk("busy_done", busy, 0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_tvalid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_pulse", $signed(out_tdata), 0);
        end else begin
          e = sbq.pop_front();
          chk("data", $signed(out_tdata), e.data);
          chk("sat", out_sat, e.sat);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end else begin
        chk("idle_data", $signed(out_tdata), 0);
        chk("idle_sat", out_sat, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cfg_vector_len = '0; cfg_shift = '0; acc_clear = 1'b0;
    in_tdata = '0; in_tvalid = 1'b0;

    tbl.push_back(mk(4, 0, 0, 4,    100,    -20,      3,     7,     90, 0));
    tbl.push_back(mk(3, 2, 2, 3,     -5,      0,      0,     0,     -2, 0));
    tbl.push_back(mk(4, 0, 0, 4,  32767,  32767,  32767, 32767,  32767, 1));
    tbl.push_back(mk(4, 0, 0, 4, -32768, -32768, -32768, -32768, -32768, 1));
    tbl.push_back(mk(4, 2, 1, 4,  32767,  32767,  32767, 32767,  32767, 0));
    tbl.push_back(mk(3, 1, 0, 3,  32767,  32767,      1,     0,  32767, 0));
    tbl.push_back(mk(3, 1, 0, 3,  32767,  32767,      2,     0,  32767, 1));
    tbl.push_back(mk(2, 0, 0, 2, -32768,     -1,      0,     0, -32768, 1));
    tbl.push_back(mk(2, 0, 3, 2, -32768,      0,      0,     0, -32768, 0));
    tbl.push_back(mk(1, 4, 0, 1,     -1,      0,      0,     0,     -1, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tdata", $signed(out_tdata), 0);
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) send(tbl[i]);

    // len 0 behaves as 1: consecutive pulses, then back-to-back len-2 vectors.
    send(mk(0, 0, 0, 1,  5, 0, 0, 0,  5, 0));
    send(mk(0, 0, 0, 1, -7, 0, 0, 0, -7, 0));
    send(mk(0, 0, 0, 1,  9, 0, 0, 0,  9, 0));
    send(mk(2, 0, 0, 2,  1, 2, 0, 0,  3, 0));
    send(mk(2, 0, 0, 2,  3, 4, 0, 0,  7, 0));

    // Abort mid-vector with a coincident sample, then a clean vector.
    cfg_vector_len = LW'(4); cfg_shift = '0; in_tdata = DW'(9); in_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0; in_tvalid = 1'b0;
    chk("busy_after_clear", busy, 0);
    send(mk(4, 0, 0, 4, 1, 1, 1, 1, 4, 0));

    // Clear coinciding with what would be the completing sample.
    cfg_vector_len = LW'(2); in_tdata = DW'(5); in_tvalid = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b1;
    @(posedge clk); #1;
    chk("busy_after_clear2", busy, 0);
    cfg_vector_len = LW'(1);
    @(posedge clk); #1;
    acc_clear = 1'b0; in_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Async reset mid-vector and during an output pulse.
    cfg_vector_len = LW'(4); in_tdata = DW'(50); in_tvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_tvalid = 1'b0;
    chk("busy_pre_rst", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cfg_vector_len = LW'(1); in_tdata = DW'(77); in_tvalid = 1'b1;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    chk("pulse_pre_rst", out_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_tvalid", out_tvalid, 0);
    chk("rst_async_tdata", $signed(out_tdata), 0);
    chk("rst_async_sat", out_sat, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(mk(2, 0, 0, 2, 10, 10, 0, 0, 20, 0));

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
